// File: rtl/trackball_pkg.sv
// Shared types and helpers for the trackball quadrature encoder:
// quadrature phase type, phase stepping and accumulator saturation.
package trackball_pkg;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_00 = 2'b00;
    localparam phase_t PH_01 = 2'b01;
    localparam phase_t PH_11 = 2'b11;
    localparam phase_t PH_10 = 2'b10;

    localparam int DELTA_W = 9;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00; backward is the reverse.
    function automatic phase_t next_phase(input phase_t cur, input logic fwd);
        phase_t nxt;
        case (cur)
            PH_00:   nxt = fwd ? PH_01 : PH_10;
            PH_01:   nxt = fwd ? PH_11 : PH_00;
            PH_11:   nxt = fwd ? PH_10 : PH_01;
            default: nxt = fwd ? PH_00 : PH_11;
        endcase
        return nxt;
    endfunction

    function automatic int sat_add(input int a, input int b, input int lim);
        int s;
        s = a + b;
        if (s > lim) begin
            s = lim;
        end else if (s < -lim) begin
            s = -lim;
        end
        return s;
    endfunction

endpackage

// File: rtl/trackball_axis.sv
// One trackball axis: saturating pending-step accumulator fed by mouse and
// joystick, drained one quadrature step per step tick.
module trackball_axis #(
    parameter int ACC_MAX = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_tick,
    input  logic              joy_tick,
    input  logic              joy_pos,
    input  logic              joy_neg,
    input  logic              stb,
    input  logic signed [8:0] delta,
    input  logic              flip,
    output logic              a,
    output logic              b,
    output logic              nonzero
);
    import trackball_pkg::*;

    // Wide enough for +-ACC_MAX and for a full mouse delta; three guard bits
    // let pend + mouse + joy - consumed be formed without overflow.
    localparam int ACC_BITS = $clog2(ACC_MAX + 1) + 1;
    localparam int ACC_W    = (ACC_BITS > DELTA_W) ? ACC_BITS : DELTA_W;
    localparam int SUM_W    = ACC_W + 3;

    logic signed [ACC_W-1:0] pend_q, pend_d;
    phase_t                  phase_q, phase_d;

    logic                    step_fwd;
    logic signed [SUM_W-1:0] consumed;
    logic signed [SUM_W-1:0] joy_v;
    logic signed [SUM_W-1:0] mouse_v;
    logic signed [SUM_W-1:0] inc;

    // The step decision looks only at the pre-update accumulator; flip
    // reverses the phase direction but not the accounting.
    always_comb begin
        step_fwd = 1'b0;
        consumed = '0;
        joy_v    = '0;
        mouse_v  = '0;
        phase_d  = phase_q;

        if (step_tick && (pend_q != '0)) begin
            step_fwd = !pend_q[ACC_W-1];
            consumed = step_fwd ? SUM_W'(1) : '1;
            phase_d  = next_phase(phase_q, step_fwd ^ flip);
        end

        if (joy_tick && joy_pos && !joy_neg) begin
            joy_v = SUM_W'(1);
        end else if (joy_tick && joy_neg && !joy_pos) begin
            joy_v = '1;
        end

        if (stb) begin
            mouse_v = {{(SUM_W-DELTA_W){delta[DELTA_W-1]}}, delta};
        end

        inc    = mouse_v + joy_v - consumed;
        pend_d = ACC_W'(sat_add(int'(pend_q), int'(inc), ACC_MAX));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q  <= '0;
            phase_q <= PH_00;
        end else begin
            pend_q  <= pend_d;
            phase_q <= phase_d;
        end
    end

    assign a       = phase_q[1];
    assign b       = phase_q[0];
    assign nonzero = (pend_q != '0);

endmodule

// File: rtl/trackball_quad_enc.sv
// Joystick/mouse to two-axis trackball quadrature converter; owns the shared
// step and joystick dividers and the registered busy flag.
module trackball_quad_enc #(
    parameter int STEP_DIV = 2500,
    parameter int JOY_DIV  = 20000,
    parameter int ACC_MAX  = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       joy_l,
    input  logic       joy_r,
    input  logic       joy_u,
    input  logic       joy_d,
    input  logic       mouse_stb,
    input  logic [8:0] mouse_dx,
    input  logic [8:0] mouse_dy,
    input  logic       flip,
    output logic       xa,
    output logic       xb,
    output logic       ya,
    output logic       yb,
    output logic       busy
);
    import trackball_pkg::*;

    localparam int STEP_CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int JOY_CW  = (JOY_DIV > 1) ? $clog2(JOY_DIV) : 1;

    logic [STEP_CW-1:0] step_cnt_q, step_cnt_d;
    logic [JOY_CW-1:0]  joy_cnt_q, joy_cnt_d;
    logic               busy_q, busy_d;
    logic               step_tick, joy_tick;
    logic               x_nz, y_nz;

    always_comb begin
        step_tick  = (step_cnt_q == STEP_CW'(STEP_DIV - 1));
        joy_tick   = (joy_cnt_q == JOY_CW'(JOY_DIV - 1));
        step_cnt_d = step_tick ? '0 : step_cnt_q + STEP_CW'(1);
        joy_cnt_d  = joy_tick ? '0 : joy_cnt_q + JOY_CW'(1);
        busy_d     = x_nz | y_nz;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt_q <= '0;
            joy_cnt_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            step_cnt_q <= step_cnt_d;
            joy_cnt_q  <= joy_cnt_d;
            busy_q     <= busy_d;
        end
    end

    // Screen y grows downward, so joy_d is the positive Y direction.
    trackball_axis #(.ACC_MAX(ACC_MAX)) u_axis_x (
        .clk      (clk),
        .reset    (reset),
        .step_tick(step_tick),
        .joy_tick (joy_tick),
        .joy_pos  (joy_r),
        .joy_neg  (joy_l),
        .stb      (mouse_stb),
        .delta    (mouse_dx),
        .flip     (flip),
        .a        (xa),
        .b        (xb),
        .nonzero  (x_nz)
    );

    trackball_axis #(.ACC_MAX(ACC_MAX)) u_axis_y (
        .clk      (clk),
        .reset    (reset),
        .step_tick(step_tick),
        .joy_tick (joy_tick),
        .joy_pos  (joy_d),
        .joy_neg  (joy_u),
        .stb      (mouse_stb),
        .delta    (mouse_dy),
        .flip     (flip),
        .a        (ya),
        .b        (yb),
        .nonzero  (y_nz)
    );

    assign busy = busy_q;

endmodule

// File: tb/tb_trackball_quad_enc.sv
// Directed self-checking bench for trackball_quad_enc (STEP_DIV=4, JOY_DIV=16).
module tb_trackball_quad_enc;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       joy_l = 1'b0, joy_r = 1'b0, joy_u = 1'b0, joy_d = 1'b0;
    logic       mouse_stb = 1'b0;
    logic [8:0] mouse_dx = '0, mouse_dy = '0;
    logic       flip = 1'b0;
    logic       xa, xb, ya, yb, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [1:0] x_vals[$];
    logic [1:0] y_vals[$];
    int         x_cyc[$];
    int         y_cyc[$];
    logic [1:0] x_prev_mon = 2'b00;
    logic [1:0] y_prev_mon = 2'b00;
    logic       busy_prev = 1'b0;
    int         busy_fall_cyc = -1;

    trackball_quad_enc #(.STEP_DIV(4), .JOY_DIV(16), .ACC_MAX(255)) dut (
        .clk      (clk),
        .reset    (reset),
        .joy_l    (joy_l),
        .joy_r    (joy_r),
        .joy_u    (joy_u),
        .joy_d    (joy_d),
        .mouse_stb(mouse_stb),
        .mouse_dx (mouse_dx),
        .mouse_dy (mouse_dy),
        .flip     (flip),
        .xa       (xa),
        .xb       (xb),
        .ya       (ya),
        .yb       (yb),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Edge recorder: every change of an axis phase is logged with its cycle.
    always @(negedge clk) begin
        if ({xa, xb} !== x_prev_mon) begin
            x_vals.push_back({xa, xb});
            x_cyc.push_back(cyc);
            x_prev_mon = {xa, xb};
        end
        if ({ya, yb} !== y_prev_mon) begin
            y_vals.push_back({ya, yb});
            y_cyc.push_back(cyc);
            y_prev_mon = {ya, yb};
        end
        if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
        busy_prev = busy;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in divider cycle 0 with all inputs idle.
    task automatic do_reset();
        joy_l = 0; joy_r = 0; joy_u = 0; joy_d = 0;
        mouse_stb = 0; mouse_dx = '0; mouse_dy = '0; flip = 0;
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        int xb0;
        reset = 1;
        tick();
        tick();
        checks++; if ({xa, xb} !== 2'b00) begin errors++; $display("[TB] FAIL reset_x: got %b expected 00", {xa, xb}); end
        checks++; if ({ya, yb} !== 2'b00) begin errors++; $display("[TB] FAIL reset_y: got %b expected 00", {ya, yb}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        reset = 0;
        mouse_stb = 1; mouse_dx = 9'd5;
        tick();
        mouse_stb = 0; mouse_dx = '0;
        repeat (3) tick();
        checks++; if ({xa, xb} !== 2'b01) begin errors++; $display("[TB] FAIL pre_reset_phase: got %b expected 01", {xa, xb}); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_busy: got %b expected 1", busy); end
        reset = 1;
        tick();
        checks++; if ({xa, xb, ya, yb} !== 4'b0000) begin errors++; $display("[TB] FAIL midreset_outputs: got %b expected 0000", {xa, xb, ya, yb}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        tick();
        reset = 0;
        xb0 = x_vals.size();
        repeat (40) tick();
        checks++; if (x_vals.size() - xb0 !== 0) begin errors++; $display("[TB] FAIL midreset_no_edges: got %0d expected 0", x_vals.size() - xb0); end
    endtask

    task automatic test_mouse_fwd();
        int xb0, yb0, c0;
        logic [1:0] exp_v[3];
        logic [1:0] prev;
        exp_v = '{2'b01, 2'b11, 2'b10};
        do_reset();
        xb0 = x_vals.size(); yb0 = y_vals.size(); c0 = cyc;
        mouse_stb = 1; mouse_dx = 9'd3;
        tick();
        mouse_stb = 0; mouse_dx = '0;
        repeat (30) tick();
        checks++; if (x_vals.size() - xb0 !== 3) begin errors++; $display("[TB] FAIL fwd_count: got %0d expected 3", x_vals.size() - xb0); end
        checks++; if (y_vals.size() - yb0 !== 0) begin errors++; $display("[TB] FAIL fwd_y_idle: got %0d edges expected 0", y_vals.size() - yb0); end
        if (x_vals.size() - xb0 == 3) begin
            prev = 2'b00;
            for (int i = 0; i < 3; i++) begin
                checks++; if (x_vals[xb0+i] !== exp_v[i]) begin errors++; $display("[TB] FAIL fwd_phase%0d: got %b expected %b", i, x_vals[xb0+i], exp_v[i]); end
                checks++; if ($countones(x_vals[xb0+i] ^ prev) != 1) begin errors++; $display("[TB] FAIL fwd_onebit%0d: got %b after %b expected one bit change", i, x_vals[xb0+i], prev); end
                prev = x_vals[xb0+i];
            end
            checks++; if (x_cyc[xb0] - c0 !== 4) begin errors++; $display("[TB] FAIL fwd_latency: got %0d expected 4", x_cyc[xb0] - c0); end
            checks++; if (x_cyc[xb0+1] - x_cyc[xb0] !== 4) begin errors++; $display("[TB] FAIL fwd_gap1: got %0d expected 4", x_cyc[xb0+1] - x_cyc[xb0]); end
            checks++; if (x_cyc[xb0+2] - x_cyc[xb0+1] !== 4) begin errors++; $display("[TB] FAIL fwd_gap2: got %0d expected 4", x_cyc[xb0+2] - x_cyc[xb0+1]); end
            checks++; if (busy_fall_cyc !== x_cyc[xb0+2] + 1) begin errors++; $display("[TB] FAIL fwd_busy_fall: got %0d expected %0d", busy_fall_cyc, x_cyc[xb0+2] + 1); end
        end
    endtask

    task automatic test_mouse_back_flip();
        int xb0;
        for (int f = 0; f < 2; f++) begin
            do_reset();
            flip = (f == 1);
            xb0 = x_vals.size();
            mouse_stb = 1; mouse_dx = 9'h1FE;
            tick();
            mouse_stb = 0; mouse_dx = '0;
            repeat (20) tick();
            checks++; if (x_vals.size() - xb0 !== 2) begin errors++; $display("[TB] FAIL back_count_flip%0d: got %0d expected 2", f, x_vals.size() - xb0); end
            if (x_vals.size() - xb0 == 2) begin
                checks++; if (x_vals[xb0] !== (f == 1 ? 2'b01 : 2'b10)) begin errors++; $display("[TB] FAIL back_first_flip%0d: got %b expected %b", f, x_vals[xb0], (f == 1 ? 2'b01 : 2'b10)); end
                checks++; if (x_vals[xb0+1] !== 2'b11) begin errors++; $display("[TB] FAIL back_second_flip%0d: got %b expected 11", f, x_vals[xb0+1]); end
            end
            flip = 0;
        end
    endtask

    task automatic test_xy_same_edge();
        int xb0, yb0;
        do_reset();
        xb0 = x_vals.size(); yb0 = y_vals.size();
        mouse_stb = 1; mouse_dx = 9'd2; mouse_dy = 9'h1FF;
        tick();
        mouse_stb = 0; mouse_dx = '0; mouse_dy = '0;
        repeat (20) tick();
        checks++; if (x_vals.size() - xb0 !== 2) begin errors++; $display("[TB] FAIL xy_xcount: got %0d expected 2", x_vals.size() - xb0); end
        checks++; if (y_vals.size() - yb0 !== 1) begin errors++; $display("[TB] FAIL xy_ycount: got %0d expected 1", y_vals.size() - yb0); end
        checks++; if ({xa, xb, ya, yb} !== 4'b1110) begin errors++; $display("[TB] FAIL xy_final: got %b expected 1110", {xa, xb, ya, yb}); end
        if (x_vals.size() - xb0 == 2 && y_vals.size() - yb0 == 1) begin
            checks++; if (y_cyc[yb0] !== x_cyc[xb0]) begin errors++; $display("[TB] FAIL xy_same_edge: got y@%0d expected x@%0d", y_cyc[yb0], x_cyc[xb0]); end
        end
    endtask

    task automatic test_saturation();
        int xb0, bad;
        logic [1:0] prev;
        do_reset();
        xb0 = x_vals.size();
        mouse_stb = 1; mouse_dx = 9'd200;
        tick();
        tick();
        mouse_stb = 0; mouse_dx = '0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL sat_busy_high: got %b expected 1", busy); end
        repeat (255 * 4 + 30) tick();
        checks++; if (x_vals.size() - xb0 !== 255) begin errors++; $display("[TB] FAIL sat_edges: got %0d expected 255", x_vals.size() - xb0); end
        checks++; if ({xa, xb} !== 2'b10) begin errors++; $display("[TB] FAIL sat_final_phase: got %b expected 10", {xa, xb}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL sat_busy_low: got %b expected 0", busy); end
        bad = 0;
        prev = 2'b00;
        for (int i = xb0; i < x_vals.size(); i++) begin
            if ($countones(x_vals[i] ^ prev) != 1) bad++;
            prev = x_vals[i];
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL sat_onebit: got %0d bad transitions expected 0", bad); end
        if (x_vals.size() - xb0 == 255) begin
            checks++; if (x_cyc[xb0+254] - x_cyc[xb0] !== 254 * 4) begin errors++; $display("[TB] FAIL sat_rate: got %0d expected %0d", x_cyc[xb0+254] - x_cyc[xb0], 254 * 4); end
        end
    endtask

    task automatic test_joystick();
        int xb0, yb0;
        do_reset();
        xb0 = x_vals.size(); yb0 = y_vals.size();
        joy_r = 1;
        repeat (64) tick();
        joy_r = 0;
        repeat (20) tick();
        checks++; if (x_vals.size() - xb0 !== 4) begin errors++; $display("[TB] FAIL joy_r_edges: got %0d expected 4", x_vals.size() - xb0); end
        checks++; if ({xa, xb} !== 2'b00) begin errors++; $display("[TB] FAIL joy_r_final: got %b expected 00", {xa, xb}); end
        checks++; if (y_vals.size() - yb0 !== 0) begin errors++; $display("[TB] FAIL joy_r_y_idle: got %0d expected 0", y_vals.size() - yb0); end

        do_reset();
        yb0 = y_vals.size();
        joy_u = 1;
        repeat (16) tick();
        joy_u = 0;
        repeat (10) tick();
        checks++; if (y_vals.size() - yb0 !== 1) begin errors++; $display("[TB] FAIL joy_u_edges: got %0d expected 1", y_vals.size() - yb0); end
        checks++; if ({ya, yb} !== 2'b10) begin errors++; $display("[TB] FAIL joy_u_phase: got %b expected 10", {ya, yb}); end

        do_reset();
        xb0 = x_vals.size(); yb0 = y_vals.size();
        joy_l = 1; joy_r = 1; joy_u = 1; joy_d = 1;
        repeat (64) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL joy_both_busy: got %b expected 0", busy); end
        joy_l = 0; joy_r = 0; joy_u = 0; joy_d = 0;
        repeat (10) tick();
        checks++; if (x_vals.size() - xb0 !== 0) begin errors++; $display("[TB] FAIL joy_both_x: got %0d expected 0", x_vals.size() - xb0); end
        checks++; if (y_vals.size() - yb0 !== 0) begin errors++; $display("[TB] FAIL joy_both_y: got %0d expected 0", y_vals.size() - yb0); end
    endtask

    // Cycle 15 carries a step tick, a joystick tick and a mouse strobe at once.
    task automatic test_back_to_back();
        int xb0, c0;
        do_reset();
        xb0 = x_vals.size(); c0 = cyc;
        repeat (12) tick();
        joy_l = 1;
        repeat (2) tick();
        mouse_stb = 1; mouse_dx = 9'd1;
        repeat (2) tick();
        mouse_stb = 0; mouse_dx = '0; joy_l = 0;
        repeat (30) tick();
        checks++; if (x_vals.size() - xb0 !== 1) begin errors++; $display("[TB] FAIL combo_edges: got %0d expected 1", x_vals.size() - xb0); end
        checks++; if ({xa, xb} !== 2'b01) begin errors++; $display("[TB] FAIL combo_phase: got %b expected 01", {xa, xb}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL combo_busy: got %b expected 0", busy); end
        if (x_vals.size() - xb0 == 1) begin
            checks++; if (x_cyc[xb0] - c0 !== 16) begin errors++; $display("[TB] FAIL combo_edge_time: got %0d expected 16", x_cyc[xb0] - c0); end
            checks++; if (busy_fall_cyc !== x_cyc[xb0] + 1) begin errors++; $display("[TB] FAIL combo_busy_fall: got %0d expected %0d", busy_fall_cyc, x_cyc[xb0] + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_mouse_fwd();
        test_mouse_back_flip();
        test_xy_same_edge();
        test_saturation();
        test_joystick();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
